// File: rtl/iq_stream.sv
// iq_stream: credit-controlled in-order instruction buffer between the fetcher
// (fc) and the decoder (dc).
//
// The buffer generates sequential fetch PCs. It tracks outstanding requests so
// that the buffer can never overflow. It delivers stored instructions to the
// decoder with a show-ahead valid/ready handshake. A ROB redirect discards
// every stored instruction and every instruction still in flight.
//
// Optional feature: define IQ_BYPASS_EN to present a response to the decoder in
// the same cycle it arrives, provided the queue is empty and nothing is being
// discarded. The default build has no bypass.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush_from_rob      redirect; has priority over every other input
//   pc_from_rob         redirect target PC
//   req_valid_to_fc     fetch request valid
//   req_pc_to_fc        fetch request PC
//   req_ready_from_fc   fetcher accepts the request
//   rsp_valid_from_fc   fetch response valid (responses return in request order)
//   rsp_instr_from_fc   fetched instruction
//   valid_to_dc         head entry valid
//   instr_to_dc         head entry instruction
//   pc_to_dc            head entry PC
//   ready_from_dc       decoder consumes the head entry
//   count_out           number of stored entries, 0..DEPTH
module iq_stream #(
  parameter int              DEPTH    = 16,
  parameter int              PTR_W    = 4,
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(4096),
  parameter logic [PC_W-1:0] PC_STEP  = PC_W'(4)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_from_rob,
  input  logic [PC_W-1:0]    pc_from_rob,
  output logic               req_valid_to_fc,
  output logic [PC_W-1:0]    req_pc_to_fc,
  input  logic               req_ready_from_fc,
  input  logic               rsp_valid_from_fc,
  input  logic [INSTR_W-1:0] rsp_instr_from_fc,
  output logic               valid_to_dc,
  output logic [INSTR_W-1:0] instr_to_dc,
  output logic [PC_W-1:0]    pc_to_dc,
  input  logic               ready_from_dc,
  output logic [PTR_W:0]     count_out
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   discard;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   pcq_wr;
  logic [PTR_W-1:0]   pcq_rd;
  logic [PC_W-1:0]    pc_next;

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PC_W-1:0]    mem_pc    [DEPTH];
  logic [PC_W-1:0]    pcq       [DEPTH];

  logic [CNT_W:0]     occupancy;
  logic               active;
  logic               accept;
  logic               rsp_live;
  logic               rsp_drop;
  logic               bypass;
  logic               bypass_take;
  logic               enq;
  logic               deq;

  // Credits cover both stored entries and live requests, so the buffer never
  // overflows. Discarded in-flight requests do not hold a credit.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign active    = !rst && !flush_from_rob;

  assign req_valid_to_fc = active && (occupancy < DEPTH_L);
  assign req_pc_to_fc    = pc_next;
  assign accept          = req_valid_to_fc && req_ready_from_fc;

  // Discarded responses always precede live ones because responses return in
  // order, so a nonzero discard count means the response is stale.
  assign rsp_live = rsp_valid_from_fc && (discard == '0);
  assign rsp_drop = rsp_valid_from_fc && (discard != '0);

`ifdef IQ_BYPASS_EN
  assign bypass = active && rsp_live && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && ready_from_dc;
  assign enq         = active && rsp_live && !bypass_take;
  assign deq         = active && (count != '0) && ready_from_dc;

  assign valid_to_dc = active && ((count != '0) || bypass);
  assign instr_to_dc = bypass ? rsp_instr_from_fc : mem_instr[head];
  assign pc_to_dc    = bypass ? pcq[pcq_rd] : mem_pc[head];
  assign count_out   = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      pc_next  <= RESET_PC;
    end else if (flush_from_rob) begin
      // A response arriving in the flush cycle retires one of the outstanding
      // requests, whether it was already stale or still live.
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= discard + inflight - CNT_W'(rsp_valid_from_fc);
      pc_next  <= pc_from_rob;
      // The PC FIFO only follows live requests. Stale responses are dropped
      // without needing a PC, so the FIFO can be emptied at once. Its
      // occupancy is then bounded by inflight, which is at most DEPTH.
      pcq_wr   <= '0;
      pcq_rd   <= '0;
    end else begin
      if (accept) begin
        pc_next <= pc_next + PC_STEP;
        pcq_wr  <= pcq_wr + 1'b1;
      end
      if (rsp_live) pcq_rd <= pcq_rd + 1'b1;
      if (rsp_drop) discard <= discard - 1'b1;
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count    <= count + CNT_W'(enq) - CNT_W'(deq);
      inflight <= inflight + CNT_W'(accept) - CNT_W'(rsp_live);
    end
  end

  // Storage has no reset; its contents are only read under count or bypass.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_instr[tail] <= rsp_instr_from_fc;
      mem_pc[tail]    <= pcq[pcq_rd];
    end
    if (accept) pcq[pcq_wr] <= pc_next;
  end

  // A response with nothing outstanding means the fetcher broke the protocol.
  assert property (@(posedge clk) disable iff (rst)
    !(rsp_valid_from_fc && (inflight == '0) && (discard == '0)));

endmodule

// File: tb/tb_iq_stream.sv
module tb_iq_stream;
  localparam int DEPTH = 16;
  localparam int PTR_W = 4;
  localparam logic [31:0] RESET_PC = 32'd4096;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_from_rob;
  logic [31:0] pc_from_rob;
  logic        req_valid_to_fc;
  logic [31:0] req_pc_to_fc;
  logic        req_ready_from_fc;
  logic        rsp_valid_from_fc;
  logic [31:0] rsp_instr_from_fc;
  logic        valid_to_dc;
  logic [31:0] instr_to_dc;
  logic [31:0] pc_to_dc;
  logic        ready_from_dc;
  logic [PTR_W:0] count_out;

  iq_stream #(.DEPTH(DEPTH), .PTR_W(PTR_W), .PC_W(32), .INSTR_W(32),
              .RESET_PC(RESET_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .rst(rst),
    .flush_from_rob(flush_from_rob), .pc_from_rob(pc_from_rob),
    .req_valid_to_fc(req_valid_to_fc), .req_pc_to_fc(req_pc_to_fc),
    .req_ready_from_fc(req_ready_from_fc),
    .rsp_valid_from_fc(rsp_valid_from_fc), .rsp_instr_from_fc(rsp_instr_from_fc),
    .valid_to_dc(valid_to_dc), .instr_to_dc(instr_to_dc), .pc_to_dc(pc_to_dc),
    .ready_from_dc(ready_from_dc), .count_out(count_out)
  );

  always #5 clk = ~clk;

  // Reference model: the fetcher's outstanding requests, oldest first. A
  // redirect marks all of them stale. m_q holds the entries the decoder
  // should see.
  req_t        fc_q[$];
  ent_t        m_q[$];
  ent_t        delivered[$];
  logic [31:0] accept_log[$];
  logic [31:0] m_pc_next = RESET_PC;
  int          serial = 0;
  int          dut_accepts = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [31:0] mk_instr(int s);
    return {8'hC0, s[23:0]};
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endfunction

  task automatic drive(int p_rr, int p_rsp, int p_dr, int p_fl);
    rst               = 1'b0;
    req_ready_from_fc = ($urandom_range(99) < p_rr);
    rsp_valid_from_fc = (fc_q.size() > 0) && ($urandom_range(99) < p_rsp);
    rsp_instr_from_fc = (fc_q.size() > 0) ? fc_q[0].instr : $urandom;
    ready_from_dc     = ($urandom_range(99) < p_dr);
    flush_from_rob    = (fc_q.size() <= DEPTH) && ($urandom_range(99) < p_fl);
    pc_from_rob       = $urandom & 32'hFFFF_FFFC;
  endtask

  // One cycle: compare DUT outputs with the model, then advance the model
  // with the inputs that the DUT samples at the coming edge.
  task automatic step();
    bit   byp;
    bit   exp_rv;
    bit   exp_v;
    int   live;
    ent_t e;
    req_t r;
    #1;
    live = 0;
    foreach (fc_q[i]) if (!fc_q[i].stale) live++;
    byp = 1'b0;
`ifdef IQ_BYPASS_EN
    byp = !rst && !flush_from_rob && rsp_valid_from_fc && (fc_q.size() > 0) &&
          !fc_q[0].stale && (m_q.size() == 0);
`endif
    exp_rv = !rst && !flush_from_rob && (m_q.size() + live < DEPTH);
    exp_v  = !rst && !flush_from_rob && ((m_q.size() > 0) || byp);
    chk("req_valid_to_fc", 32'(req_valid_to_fc), 32'(exp_rv));
    if (!rst) chk("req_pc_to_fc", req_pc_to_fc, m_pc_next);
    chk("valid_to_dc", 32'(valid_to_dc), 32'(exp_v));
    if (exp_v && valid_to_dc) begin
      chk("instr_to_dc", instr_to_dc, byp ? fc_q[0].instr : m_q[0].instr);
      chk("pc_to_dc", pc_to_dc, byp ? fc_q[0].pc : m_q[0].pc);
    end
    chk("count_out", 32'(count_out), 32'(m_q.size()));

    if (req_valid_to_fc && req_ready_from_fc) begin
      dut_accepts++;
      accept_log.push_back(req_pc_to_fc);
    end
    if (valid_to_dc && ready_from_dc) begin
      e.instr = instr_to_dc;
      e.pc    = pc_to_dc;
      delivered.push_back(e);
    end

    if (rst) begin
      fc_q.delete();
      m_q.delete();
      m_pc_next = RESET_PC;
    end else if (flush_from_rob) begin
      if (rsp_valid_from_fc) void'(fc_q.pop_front());
      foreach (fc_q[i]) fc_q[i].stale = 1'b1;
      m_q.delete();
      m_pc_next = pc_from_rob;
    end else begin
      if ((m_q.size() > 0) && ready_from_dc) void'(m_q.pop_front());
      if (rsp_valid_from_fc) begin
        r = fc_q.pop_front();
        if (!r.stale && !(byp && ready_from_dc)) begin
          e.instr = r.instr;
          e.pc    = r.pc;
          m_q.push_back(e);
        end
      end
      if (exp_rv && req_ready_from_fc) begin
        r.pc    = m_pc_next;
        r.instr = mk_instr(serial);
        r.stale = 1'b0;
        fc_q.push_back(r);
        serial++;
        m_pc_next = m_pc_next + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiesce();
    int n;
    n = 0;
    while ((fc_q.size() > 0 || m_q.size() > 0) && n < 200) begin
      drive(0, 100, 100, 0);
      step();
      n++;
    end
    if (fc_q.size() > 0 || m_q.size() > 0) timeout("quiesce");
  endtask

  initial begin
    int n;
    int sflush;

    rst = 1'b1; flush_from_rob = 1'b0; pc_from_rob = '0;
    req_ready_from_fc = 1'b0; rsp_valid_from_fc = 1'b0;
    rsp_instr_from_fc = '0; ready_from_dc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    step();

    // Fill with an always-ready fetcher (1-cycle responses) and a stalled decoder.
    for (int i = 0; i < 30; i++) begin
      drive(100, 100, 0, 0);
      step();
    end
    chk("fill_accepts", 32'(dut_accepts), 32'd16);
    chk("fill_pc0", accept_log[0], 32'd4096);
    chk("fill_pc1", accept_log[1], 32'd4100);
    chk("fill_pc2", accept_log[2], 32'd4104);
    chk("fill_count", 32'(count_out), 32'd16);
    chk("fill_req_valid", 32'(req_valid_to_fc), 32'd0);

    delivered.delete();
    n = 0;
    while (delivered.size() < 16 && n < 40) begin
      drive(0, 100, 100, 0);
      step();
      n++;
    end
    if (delivered.size() < 16) timeout("drain");
    else for (int i = 0; i < 16; i++)
      chk("drain_pc", delivered[i].pc, 32'd4096 + 32'(4 * i));
    quiesce();

    // Wrap: stream 40 instructions with random handshakes, no redirects.
    delivered.delete();
    n = 0;
    while (delivered.size() < 40 && n < 1000) begin
      drive(80, 70, 50, 0);
      step();
      n++;
    end
    if (delivered.size() < 40) timeout("wrap");
    else for (int i = 1; i < 40; i++) begin
      chk("wrap_instr_seq", delivered[i].instr, delivered[i-1].instr + 32'd1);
      chk("wrap_pc_seq", delivered[i].pc, delivered[i-1].pc + 32'd4);
    end
    quiesce();

    // Redirect with 5 stored and 3 in flight.
    for (int i = 0; i < 8; i++) begin drive(100, 0, 0, 0); step(); end
    for (int i = 0; i < 5; i++) begin drive(0, 100, 0, 0); step(); end
    chk("pre_flush_count", 32'(count_out), 32'd5);
    drive(0, 0, 100, 0);
    flush_from_rob = 1'b1;
    pc_from_rob    = 32'h200;
    sflush = serial;
    step();
    chk("flush_count", 32'(count_out), 32'd0);
    delivered.delete();
    n = 0;
    while (delivered.size() == 0 && n < 60) begin
      drive(100, 100, 100, 0);
      step();
      n++;
    end
    if (delivered.size() == 0) timeout("flush_deliver");
    else begin
      chk("flush_first_pc", delivered[0].pc, 32'h200);
      chk("flush_first_instr", delivered[0].instr, mk_instr(sflush));
    end
    quiesce();

    // Redirect coinciding with a response and a dequeue.
    for (int i = 0; i < 4; i++) begin drive(100, 0, 0, 0); step(); end
    for (int i = 0; i < 2; i++) begin drive(0, 100, 0, 0); step(); end
    drive(0, 100, 100, 0);
    rsp_valid_from_fc = 1'b1;
    rsp_instr_from_fc = fc_q[0].instr;
    flush_from_rob    = 1'b1;
    pc_from_rob       = 32'h300;
    sflush = serial;
    #1;
    chk("flush_rsp_valid_to_dc", 32'(valid_to_dc), 32'd0);
    delivered.delete();
    step();
    n = 0;
    while (delivered.size() == 0 && n < 60) begin
      drive(100, 100, 100, 0);
      step();
      n++;
    end
    if (delivered.size() == 0) timeout("flush_rsp_deliver");
    else begin
      chk("flush_rsp_first_pc", delivered[0].pc, 32'h300);
      chk("flush_rsp_first_instr", delivered[0].instr, mk_instr(sflush));
    end
    quiesce();

    // Empty queue, one response arriving with the decoder ready.
    drive(100, 0, 0, 0);
    step();
    drive(0, 0, 100, 0);
    fc_q[0].instr     = 32'h0000_0013;
    rsp_valid_from_fc = 1'b1;
    rsp_instr_from_fc = 32'h0000_0013;
    #1;
`ifdef IQ_BYPASS_EN
    chk("bypass_valid", 32'(valid_to_dc), 32'd1);
    chk("bypass_instr", instr_to_dc, 32'h0000_0013);
    step();
    chk("bypass_count", 32'(count_out), 32'd0);
`else
    chk("nobypass_valid", 32'(valid_to_dc), 32'd0);
    step();
    chk("nobypass_count", 32'(count_out), 32'd1);
    chk("nobypass_instr", instr_to_dc, 32'h0000_0013);
`endif
    quiesce();

    // Random traffic with occasional redirects.
    for (int i = 0; i < 1500; i++) begin
      drive(70, 60, 60, 3);
      step();
    end
    quiesce();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
